// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle control sequencer of the 8-bit
// accumulator datapath: opcode constants, the sequencer state encoding,
// register-file write-source codes, ALU operation codes and the packed
// control vector that the decoder hands back to the top level.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Instruction opcodes as delivered by instructMem
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LI   = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Register-file write source select
  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_IMM = 2'd1;
  localparam logic [1:0] WSEL_MEM = 2'd2;

  // ALU operation and B-operand select
  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_SUB  = 1'b1;
  localparam logic BSEL_REG = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  // PC next-value select
  localparam logic PCSEL_INC    = 1'b0;
  localparam logic PCSEL_BRANCH = 1'b1;

  // Control vector driven towards the datapath
  typedef struct packed {
    logic       pc_en;
    logic       pc_sel;
    logic       ir_load;
    logic       rf_we;
    logic       rf_waddr;
    logic [1:0] rf_wsel;
    logic       alu_op;
    logic       alu_bsel;
    logic       mem_req;
    logic       mem_we;
    logic       halted;
  } ctrl_t;

  // True for opcodes whose result comes out of the ALU
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

  // Register-file write source for an opcode that reaches write-back
  function automatic logic [1:0] wsel_for(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_LI:   sel = WSEL_IMM;
      OP_LD:   sel = WSEL_MEM;
      default: sel = WSEL_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_decode
// Combinational output decoder of the control sequencer. Maps the current
// state plus the latched instruction fields to the datapath control vector.
// Ports:
//   state    in  current sequencer state
//   op       in  latched opcode (captured in DECODE)
//   rt       in  latched target register index
//   zero_in  in  datapath flag, selected rt register equals 0
//   mem_ack  in  data-memory completion
//   ctrl     out control vector (all zero unless a state asserts a field)
// -----------------------------------------------------------------------------
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] op,
  input  logic       rt,
  input  logic       zero_in,
  input  logic       mem_ack,
  output ctrl_t      ctrl
);

  // Every field defaults to 0 so idle cycles and unlisted fields stay quiet.
  // The ALU controls are only driven in EXEC; the datapath captures the ALU
  // result at the end of that cycle and write-back uses the captured value.
  // A store retires in the MEM cycle that sees mem_ack, so its PC pulse is
  // qualified by the acknowledge to keep exactly one pulse per instruction.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_IDLE: ;
      ST_FETCH: begin
        ctrl.ir_load = 1'b1;
      end
      ST_DECODE: ;
      ST_EXEC: begin
        if (is_alu_op(op)) begin
          ctrl.alu_op   = (op == OP_SUB)  ? ALU_SUB  : ALU_ADD;
          ctrl.alu_bsel = (op == OP_ADDI) ? BSEL_IMM : BSEL_REG;
        end
        if (op == OP_BEQZ) begin
          ctrl.pc_en  = 1'b1;
          ctrl.pc_sel = zero_in ? PCSEL_BRANCH : PCSEL_INC;
        end
      end
      ST_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = (op == OP_ST);
        ctrl.pc_en   = (op == OP_ST) && mem_ack;
      end
      ST_WB: begin
        ctrl.rf_we    = 1'b1;
        ctrl.rf_waddr = rt;
        ctrl.rf_wsel  = wsel_for(op);
        ctrl.pc_en    = 1'b1;
        ctrl.pc_sel   = PCSEL_INC;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle control sequencer for the 8-bit accumulator datapath. Walks each
// instruction through FETCH, DECODE, EXEC, MEM and WB, latches the instruction
// fields in DECODE and counts retired instructions.
// Ports:
//   sysclk       in  system clock, rising edge
//   reset        in  synchronous active-high reset
//   start        in  leave IDLE when sampled high
//   opcode       in  [2:0] opcode from instructMem
//   rt           in  target register index
//   rs           in  source register index (addresses the register file
//                    directly, the sequencer only passes it by)
//   aux          in  [2:0] immediate field
//   zero_in      in  selected rt register equals 0
//   mem_ack      in  data-memory completion, honoured only in MEM
//   pc_en        out PC update
//   pc_sel       out 0 = PC+1, 1 = PC+sext(aux)
//   ir_load      out latch the instruction fields
//   rf_we        out register-file write
//   rf_waddr     out register-file write index
//   rf_wsel      out [1:0] write source: 0 ALU, 1 aux, 2 memory
//   alu_op       out 0 add, 1 sub
//   alu_bsel     out 0 reg[rs], 1 aux
//   mem_req      out data-memory request
//   mem_we       out request is a store
//   halted       out HALT retired
//   instr_count  out [CNT_W-1:0] retired instructions, wraps
// -----------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             rt,
  input  logic             rs,
  input  logic [2:0]       aux,
  input  logic             zero_in,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             ir_load,
  output logic             rf_we,
  output logic             rf_waddr,
  output logic [1:0]       rf_wsel,
  output logic             alu_op,
  output logic             alu_bsel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [2:0]       op_q;
  logic             rt_q;
  logic [2:0]       aux_q;
  logic [CNT_W-1:0] count_q;
  ctrl_t            ctrl;

  // aux is held with the rest of the instruction but only the datapath acts
  // on the immediate; rs never passes through the sequencer's state.
  logic unused_fields;
  assign unused_fields = ^{rs, aux_q};

  // All outputs come from the current state and the latched fields; the
  // live opcode/aux are only looked at while in DECODE.
  cpu_ctrl_decode u_decode (
    .state   (state),
    .op      (op_q),
    .rt      (rt_q),
    .zero_in (zero_in),
    .mem_ack (mem_ack),
    .ctrl    (ctrl)
  );

  // State register, field latches and retired counter. The counter steps on
  // the edge that leaves an instruction's retiring cycle (the one carrying
  // its PC pulse) and on the edge entering HALT, which is why HALT counts
  // exactly once. Reset wins over everything, including a pending mem_ack.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      rt_q    <= 1'b0;
      aux_q   <= '0;
      count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          op_q  <= opcode;
          rt_q  <= rt;
          aux_q <= aux;
          if (opcode == OP_HALT) begin
            state   <= ST_HALT;
            count_q <= count_q + CNT_ONE;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_LD, OP_ST: begin
              state <= ST_MEM;
            end
            OP_BEQZ: begin
              state   <= ST_FETCH;
              count_q <= count_q + CNT_ONE;
            end
            OP_ADD, OP_SUB, OP_LI, OP_ADDI: begin
              state <= ST_WB;
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (op_q == OP_ST) begin
              state   <= ST_FETCH;
              count_q <= count_q + CNT_ONE;
            end else begin
              state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          state   <= ST_FETCH;
          count_q <= count_q + CNT_ONE;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign pc_sel      = ctrl.pc_sel;
  assign ir_load     = ctrl.ir_load;
  assign rf_we       = ctrl.rf_we;
  assign rf_waddr    = ctrl.rf_waddr;
  assign rf_wsel     = ctrl.rf_wsel;
  assign alu_op      = ctrl.alu_op;
  assign alu_bsel    = ctrl.alu_bsel;
  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign halted      = ctrl.halted;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Self-checking bench for cpu_control_fsm. Each instruction is expanded into
// its cycle-by-cycle expectations from the instruction-level rules (cycle
// budget, which cycle pulses the PC, which cycle writes the register file),
// queued, then replayed against the DUT. The counter is narrowed to 3 bits so
// the wrap-around is reached by the program.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;

  localparam int CW = 3;

  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_LI   = 3'b010;
  localparam logic [2:0] OPC_ADDI = 3'b011;
  localparam logic [2:0] OPC_LD   = 3'b100;
  localparam logic [2:0] OPC_ST   = 3'b101;
  localparam logic [2:0] OPC_BEQZ = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  typedef struct {
    bit            chk;
    logic          reset;
    logic          start;
    logic          mem_ack;
    logic          zero_in;
    logic          rt;
    logic          rs;
    logic [2:0]    opcode;
    logic [2:0]    aux;
    logic          pc_en;
    logic          pc_sel;
    logic          ir_load;
    logic          rf_we;
    logic          rf_waddr;
    logic [1:0]    rf_wsel;
    logic          alu_op;
    logic          alu_bsel;
    logic          mem_req;
    logic          mem_we;
    logic          halted;
    logic [CW-1:0] count;
  } cyc_t;

  logic          sysclk;
  logic          reset;
  logic          start;
  logic [2:0]    opcode;
  logic          rt;
  logic          rs;
  logic [2:0]    aux;
  logic          zero_in;
  logic          mem_ack;
  logic          pc_en;
  logic          pc_sel;
  logic          ir_load;
  logic          rf_we;
  logic          rf_waddr;
  logic [1:0]    rf_wsel;
  logic          alu_op;
  logic          alu_bsel;
  logic          mem_req;
  logic          mem_we;
  logic          halted;
  logic [CW-1:0] instr_count;

  cyc_t          q[$];
  cyc_t          cur;
  bit            cur_valid = 1'b0;
  logic [CW-1:0] model_count = '0;

  int checks   = 0;
  int failures = 0;

  int obs_pc_en   = 0;
  int obs_pc_sel  = 0;
  int obs_rf_we   = 0;
  int obs_mem_req = 0;
  int obs_mem_we  = 0;
  int obs_halted  = 0;
  int base_pc_en, base_pc_sel, base_rf_we, base_mem_req, base_mem_we, base_halted;

  cpu_control_fsm #(.CNT_W(CW)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .rt          (rt),
    .rs          (rs),
    .aux         (aux),
    .zero_in     (zero_in),
    .mem_ack     (mem_ack),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .ir_load     (ir_load),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wsel     (rf_wsel),
    .alu_op      (alu_op),
    .alu_bsel    (alu_bsel),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // 10 time-unit clock
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Safety net: the program is a few hundred time units long
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, actual, required);
    end
  endtask

  // A cycle with nothing expected: outputs low, don't-care inputs randomised
  function automatic cyc_t blankCycle();
    cyc_t c;
    c.chk      = 1'b1;
    c.reset    = 1'b0;
    c.start    = ($urandom_range(0, 1) != 0);
    c.mem_ack  = ($urandom_range(0, 1) != 0);
    c.zero_in  = ($urandom_range(0, 1) != 0);
    c.rt       = ($urandom_range(0, 1) != 0);
    c.rs       = ($urandom_range(0, 1) != 0);
    c.opcode   = 3'($urandom_range(0, 7));
    c.aux      = 3'($urandom_range(0, 7));
    c.pc_en    = 1'b0;
    c.pc_sel   = 1'b0;
    c.ir_load  = 1'b0;
    c.rf_we    = 1'b0;
    c.rf_waddr = 1'b0;
    c.rf_wsel  = 2'd0;
    c.alu_op   = 1'b0;
    c.alu_bsel = 1'b0;
    c.mem_req  = 1'b0;
    c.mem_we   = 1'b0;
    c.halted   = 1'b0;
    c.count    = model_count;
    return c;
  endfunction

  task automatic pushReset(input int n);
    cyc_t c;
    model_count = '0;
    for (int i = 0; i < n; i++) begin
      c = blankCycle();
      c.reset = 1'b1;
      c.chk   = (i > 0);
      q.push_back(c);
    end
  endtask

  task automatic pushIdle(input int n, input bit start_last);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blankCycle();
      c.start = start_last && (i == n - 1);
      q.push_back(c);
    end
  endtask

  // Halted cycles; start toggles to show it is ignored, optional reset last
  task automatic pushHalt(input int n, input bit reset_last);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blankCycle();
      c.halted = 1'b1;
      c.start  = (i % 2 == 0);
      c.reset  = reset_last && (i == n - 1);
      q.push_back(c);
    end
    if (reset_last) model_count = '0;
  endtask

  // Expand one instruction into its cycles. waitc = MEM cycles without ack;
  // reset_at >= 0 asserts reset in that MEM cycle and abandons the instruction.
  task automatic pushInstr(input logic [2:0] op, input logic rt_i, input logic rs_i,
                           input logic [2:0] aux_i, input logic zero_i,
                           input int waitc, input int reset_at);
    cyc_t c;
    bit   done;
    done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c = blankCycle();
      c.opcode  = op;
      c.rt      = rt_i;
      c.rs      = rs_i;
      c.aux     = aux_i;
      c.ir_load = (i == 0);
      q.push_back(c);
    end
    if (op == OPC_HALT) begin
      model_count = model_count + 1'b1;
      done = 1'b1;
    end
    if (!done) begin
      c = blankCycle();
      if (op == OPC_SUB)  c.alu_op   = 1'b1;
      if (op == OPC_ADDI) c.alu_bsel = 1'b1;
      if (op == OPC_BEQZ) begin
        c.zero_in = zero_i;
        c.pc_en   = 1'b1;
        c.pc_sel  = zero_i;
      end
      q.push_back(c);
      if (op == OPC_BEQZ) begin
        model_count = model_count + 1'b1;
        done = 1'b1;
      end
    end
    if (!done && (op == OPC_LD || op == OPC_ST)) begin
      for (int i = 0; i <= waitc && !done; i++) begin
        c = blankCycle();
        c.mem_req = 1'b1;
        c.mem_we  = (op == OPC_ST);
        c.mem_ack = (i == waitc);
        if (i == reset_at) begin
          c.mem_ack   = 1'b0;
          c.reset     = 1'b1;
          model_count = '0;
          done        = 1'b1;
        end else if (op == OPC_ST && i == waitc) begin
          c.pc_en = 1'b1;
        end
        q.push_back(c);
      end
      if (!done && op == OPC_ST) begin
        model_count = model_count + 1'b1;
        done = 1'b1;
      end
    end
    if (!done) begin
      c = blankCycle();
      c.rf_we    = 1'b1;
      c.rf_waddr = rt_i;
      c.rf_wsel  = (op == OPC_LI) ? 2'd1 : (op == OPC_LD) ? 2'd2 : 2'd0;
      c.pc_en    = 1'b1;
      q.push_back(c);
      model_count = model_count + 1'b1;
    end
  endtask

  // Replay the queued cycles; optionally pin the counter in the first cycle
  task automatic applyStimulus(input int lit_first);
    bit first;
    first = 1'b1;
    while (q.size() > 0) begin
      @(posedge sysclk);
      #1;
      cur     = q.pop_front();
      reset   = cur.reset;
      start   = cur.start;
      opcode  = cur.opcode;
      rt      = cur.rt;
      rs      = cur.rs;
      aux     = cur.aux;
      zero_in = cur.zero_in;
      mem_ack = cur.mem_ack;
      cur_valid = 1'b1;
      if (first) begin
        first = 1'b0;
        if (lit_first >= 0) begin
          @(negedge sysclk);
          #1;
          checkOutput("phase_start_count", 32'(instr_count), 32'(lit_first));
        end
      end
    end
    @(negedge sysclk);
    #1;
  endtask

  task automatic snap();
    base_pc_en   = obs_pc_en;
    base_pc_sel  = obs_pc_sel;
    base_rf_we   = obs_rf_we;
    base_mem_req = obs_mem_req;
    base_mem_we  = obs_mem_we;
    base_halted  = obs_halted;
  endtask

  // Per-cycle comparison against the queued expectation, on the falling edge
  always @(negedge sysclk) begin
    if (cur_valid && cur.chk) begin
      checkOutput("pc_en",       32'(pc_en),       32'(cur.pc_en));
      checkOutput("pc_sel",      32'(pc_sel),      32'(cur.pc_sel));
      checkOutput("ir_load",     32'(ir_load),     32'(cur.ir_load));
      checkOutput("rf_we",       32'(rf_we),       32'(cur.rf_we));
      checkOutput("rf_waddr",    32'(rf_waddr),    32'(cur.rf_waddr));
      checkOutput("rf_wsel",     32'(rf_wsel),     32'(cur.rf_wsel));
      checkOutput("alu_op",      32'(alu_op),      32'(cur.alu_op));
      checkOutput("alu_bsel",    32'(alu_bsel),    32'(cur.alu_bsel));
      checkOutput("mem_req",     32'(mem_req),     32'(cur.mem_req));
      checkOutput("mem_we",      32'(mem_we),      32'(cur.mem_we));
      checkOutput("halted",      32'(halted),      32'(cur.halted));
      checkOutput("instr_count", 32'(instr_count), 32'(cur.count));
      obs_pc_en   <= obs_pc_en   + ((pc_en   === 1'b1) ? 1 : 0);
      obs_pc_sel  <= obs_pc_sel  + ((pc_sel  === 1'b1) ? 1 : 0);
      obs_rf_we   <= obs_rf_we   + ((rf_we   === 1'b1) ? 1 : 0);
      obs_mem_req <= obs_mem_req + ((mem_req === 1'b1) ? 1 : 0);
      obs_mem_we  <= obs_mem_we  + ((mem_we  === 1'b1) ? 1 : 0);
      obs_halted  <= obs_halted  + ((halted  === 1'b1) ? 1 : 0);
    end
  end

  // Directed program: each phase is queued, length-pinned, replayed, then
  // its observed pulse totals are checked against hand-counted numbers.
  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; rt = 1'b0; rs = 1'b0;
    aux = '0; zero_in = 1'b0; mem_ack = 1'b0;

    // Reset, start, ADD rt=1 rs=0
    pushReset(2);
    pushIdle(2, 1'b1);
    pushInstr(OPC_ADD, 1'b1, 1'b0, 3'd4, 1'b0, 0, -1);
    checkOutput("len_add", 32'(q.size()), 32'd8);
    snap();
    applyStimulus(0);
    checkOutput("add_pc_en", 32'(obs_pc_en - base_pc_en), 32'd1);
    checkOutput("add_rf_we", 32'(obs_rf_we - base_rf_we), 32'd1);

    // LD aux=5, ack after 3 waiting cycles
    pushInstr(OPC_LD, 1'b1, 1'b0, 3'd5, 1'b0, 3, -1);
    checkOutput("len_ld", 32'(q.size()), 32'd8);
    snap();
    applyStimulus(1);
    checkOutput("ld_mem_req", 32'(obs_mem_req - base_mem_req), 32'd4);
    checkOutput("ld_mem_we",  32'(obs_mem_we - base_mem_we),   32'd0);

    // BEQZ taken
    pushInstr(OPC_BEQZ, 1'b0, 1'b1, 3'b110, 1'b1, 0, -1);
    checkOutput("len_beqz_t", 32'(q.size()), 32'd3);
    snap();
    applyStimulus(2);
    checkOutput("beqz_t_pc_sel", 32'(obs_pc_sel - base_pc_sel), 32'd1);
    checkOutput("beqz_t_rf_we",  32'(obs_rf_we - base_rf_we),   32'd0);

    // BEQZ not taken
    pushInstr(OPC_BEQZ, 1'b1, 1'b0, 3'b110, 1'b0, 0, -1);
    checkOutput("len_beqz_n", 32'(q.size()), 32'd3);
    snap();
    applyStimulus(3);
    checkOutput("beqz_n_pc_en",  32'(obs_pc_en - base_pc_en),   32'd1);
    checkOutput("beqz_n_pc_sel", 32'(obs_pc_sel - base_pc_sel), 32'd0);

    // ST aux=2, ack in the first MEM cycle
    pushInstr(OPC_ST, 1'b1, 1'b0, 3'd2, 1'b0, 0, -1);
    checkOutput("len_st", 32'(q.size()), 32'd4);
    snap();
    applyStimulus(4);
    checkOutput("st_mem_we", 32'(obs_mem_we - base_mem_we), 32'd1);
    checkOutput("st_rf_we",  32'(obs_rf_we - base_rf_we),   32'd0);

    // SUB, LI, ADDI back to back
    pushInstr(OPC_SUB,  1'b0, 1'b1, 3'd0, 1'b0, 0, -1);
    pushInstr(OPC_LI,   1'b1, 1'b0, 3'd7, 1'b0, 0, -1);
    pushInstr(OPC_ADDI, 1'b0, 1'b1, 3'd3, 1'b0, 0, -1);
    checkOutput("len_alu3", 32'(q.size()), 32'd12);
    snap();
    applyStimulus(5);
    checkOutput("alu3_rf_we", 32'(obs_rf_we - base_rf_we), 32'd3);

    // HALT (counter wraps 7 -> 0 -> 1), start pulses ignored, reset at end
    pushInstr(OPC_HALT, 1'b0, 1'b0, 3'd0, 1'b0, 0, -1);
    pushHalt(5, 1'b1);
    checkOutput("len_halt", 32'(q.size()), 32'd7);
    snap();
    applyStimulus(0);
    checkOutput("halt_cycles", 32'(obs_halted - base_halted), 32'd5);
    checkOutput("halt_pc_en",  32'(obs_pc_en - base_pc_en),   32'd0);

    // Restart, LD aborted by reset in its second MEM cycle
    pushIdle(1, 1'b1);
    pushInstr(OPC_LD, 1'b1, 1'b0, 3'd4, 1'b0, 3, 1);
    checkOutput("len_abort", 32'(q.size()), 32'd6);
    snap();
    applyStimulus(0);
    checkOutput("abort_mem_req", 32'(obs_mem_req - base_mem_req), 32'd2);
    checkOutput("abort_pc_en",   32'(obs_pc_en - base_pc_en),     32'd0);

    // Restart after the abort: ADDI then ST with two wait cycles
    pushIdle(2, 1'b1);
    pushInstr(OPC_ADDI, 1'b1, 1'b0, 3'd1, 1'b0, 0, -1);
    pushInstr(OPC_ST,   1'b0, 1'b1, 3'd3, 1'b0, 2, -1);
    pushIdle(0, 1'b0);
    checkOutput("len_restart", 32'(q.size()), 32'd12);
    snap();
    applyStimulus(0);
    checkOutput("restart_pc_en",   32'(obs_pc_en - base_pc_en),     32'd2);
    checkOutput("restart_mem_we",  32'(obs_mem_we - base_mem_we),   32'd3);
    checkOutput("restart_count",   32'(instr_count),                32'd1);

    cur_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the 8-bit accumulator-style datapath built around `program_counter` and `instructMem`. It walks each instruction through fetch, decode, execute, memory and write-back. It drives the PC, instruction register, register file, ALU and data-memory handshake from the latched `opcode`, `rt`, `rs` and `aux` fields. It sits between the instruction memory outputs and the datapath enables, and counts retired instructions for the bench.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `sysclk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  leaves IDLE on a sampled 1.
- `opcode`  in  3  instruction opcode from `instructMem`.
- `rt`  in  1  target register index.
- `rs`  in  1  source register index.
- `aux`  in  3  immediate field.
- `zero_in`  in  1  datapath flag: selected `rt` register equals 0.
- `mem_ack`  in  1  data-memory completion, sampled in MEM.
- `pc_en`  out  1  PC update this cycle.
- `pc_sel`  out  1  0 selects PC+1; 1 selects PC+sext(aux).
- `ir_load`  out  1  latch the instruction fields.
- `rf_we`  out  1  register-file write.
- `rf_waddr`  out  1  write index (latched `rt`).
- `rf_wsel`  out  2  write source: 0 = ALU, 1 = aux zero-extended, 2 = memory data.
- `alu_op`  out  1  0 = add, 1 = sub.
- `alu_bsel`  out  1  ALU B operand: 0 = reg[rs], 1 = aux zero-extended.
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  request is a store; valid only while `mem_req`=1.
- `halted`  out  1  HALT retired.
- `instr_count`  out  CNT_W  retired instructions.

## Operation
- Opcodes:
  - 000 ADD: rt = rt + rs.
  - 001 SUB: rt = rt − rs.
  - 010 LI: rt = aux.
  - 011 ADDI: rt = rt + aux.
  - 100 LD: rt = mem[aux].
  - 101 ST: mem[aux] = rt.
  - 110 BEQZ: if rt == 0, PC = PC + sext(aux).
  - 111 HALT.
- States are IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
- IDLE → FETCH when `start`=1; otherwise the FSM stays in IDLE.
- FETCH: `ir_load`=1. Next state is DECODE.
- DECODE:
  - Opcode, rt and aux are held in internal registers.
  - HALT → HALT state. Every other opcode → EXEC.
- EXEC:
  - ALU ops set `alu_op`/`alu_bsel` per opcode; next state is WB.
  - LI → WB.
  - LD/ST → MEM.
  - BEQZ asserts `pc_en`=1 and `pc_sel`=`zero_in`, increments `instr_count`, then → FETCH.
- MEM:
  - `mem_req`=1 every cycle in MEM; `mem_we`=1 for ST.
  - Stay in MEM while `mem_ack`=0.
  - On `mem_ack`=1, LD → WB. ST asserts `pc_en`=1, increments `instr_count`, then → FETCH.
- WB:
  - `rf_we`=1, `rf_waddr` = latched rt, `rf_wsel` per opcode.
  - `pc_en`=1 with `pc_sel`=0; `instr_count` increments.
  - Next state is FETCH.
- HALT:
  - `halted`=1 and `instr_count` increments once on entry.
  - The FSM stays here until `reset`; `start` is ignored.
- All outputs are Moore-decoded from the current state and the latched fields. `opcode`/`aux` are never used combinationally after DECODE.
- `instr_count` wraps modulo 2^CNT_W.

## Timing
- On reset, all outputs are 0, the state is IDLE, `instr_count`=0 and the latched fields are 0.
- Reset has priority over every other input in every state:
  - Reset during MEM drops `mem_req` on the next edge.
  - Reset during HALT clears `halted`.
- Cycles per instruction, counted from FETCH:
  - ALU ops and LI: 4.
  - BEQZ: 3.
  - ST: 4 + wait.
  - LD: 5 + wait, where wait is the number of cycles with `mem_ack`=0 in MEM.
  - HALT: 3, counting the FETCH, DECODE and HALT-entry cycles.
- `mem_ack` while `mem_req`=0 is ignored.
- Exactly one `pc_en` pulse per retired non-HALT instruction. HALT never pulses `pc_en`.
- `start` held high continuously has no effect beyond the first exit from IDLE.

## Structure
- Package `cpu_pkg`:
  - Opcode constants OP_ADD through OP_HALT.
  - State encoding constants.
  - `rf_wsel` source codes.
  - ALU op codes.
- One sub-module, `cpu_ctrl_decode`: combinational map from (state, latched opcode, `zero_in`) to the output control vector. The top holds the state register, the field latches and the counter.

## Test plan
- Reset then `start`=1 with ADD rt=1 rs=0 → FETCH/DECODE/EXEC/WB. In WB: `rf_we`=1, `rf_waddr`=1, `rf_wsel`=0, `pc_en`=1, `pc_sel`=0. Afterwards `instr_count`=1.
- LD aux=5 with `mem_ack` delayed 3 cycles → `mem_req` high for 4 cycles with `mem_we`=0. WB follows with `rf_wsel`=2. Total 8 cycles.
- BEQZ aux=3'b110:
  - `zero_in`=1 → `pc_en`=1, `pc_sel`=1 in EXEC.
  - `zero_in`=0 → `pc_sel`=0.
  - Both cases take 3 cycles and never assert `rf_we`.
- ST aux=2 with `mem_ack` asserted in the first MEM cycle → `mem_req`=`mem_we`=1 for 1 cycle, `pc_en`=1 in that same cycle, `rf_we` never asserted.
- HALT → `halted`=1 from the cycle after DECODE and `instr_count` increments once. Subsequent `start` pulses are ignored. `reset` clears `halted` and returns the FSM to IDLE.
- `reset` asserted during a MEM wait → next cycle all outputs are 0 and the state is IDLE. A new `start` re-fetches correctly.
